// File: rtl/bus_datapath_pkg.sv
// bus_datapath_pkg: definitions shared by the single-bus datapath.
//   DATA_W   - bus / register width
//   alu_op_e - 5-bit ALU opcode encodings carried on IRout
package bus_datapath_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [4:0] {
    OP_ADD = 5'b00011,
    OP_SUB = 5'b00100,
    OP_SHR = 5'b00101,
    OP_SHL = 5'b00110,
    OP_ROR = 5'b00111,
    OP_ROL = 5'b01000,
    OP_AND = 5'b01001,
    OP_OR  = 5'b01010,
    OP_MUL = 5'b01110,
    OP_DIV = 5'b01111,
    OP_NEG = 5'b10000,
    OP_NOT = 5'b10001
  } alu_op_e;

endpackage

// File: rtl/bus_datapath_alu.sv
// alu: combinational ALU with a 64-bit result {hi, lo}.
//   op_i  - opcode (alu_op_e encoding); unknown opcodes give 0
//   a_i   - operand A (Y register)
//   b_i   - operand B (bus)
//   res_o - result; 32-bit operations leave the upper half 0
module alu
  import bus_datapath_pkg::*;
(
  input  logic [4:0]          op_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [2*DATA_W-1:0] res_o
);

  logic [4:0]                 sh;
  logic [2*DATA_W-1:0]        rot;
  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;

  assign sh    = b_i[4:0];
  assign a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
  assign b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};

  always_comb begin
    res_o = '0;
    rot   = '0;
    case (op_i)
      OP_ADD: res_o[DATA_W-1:0] = a_i + b_i;
      OP_SUB: res_o[DATA_W-1:0] = a_i - b_i;
      OP_SHR: res_o[DATA_W-1:0] = a_i >> sh;
      OP_SHL: res_o[DATA_W-1:0] = a_i << sh;
      // Rotates shift a doubled copy so a zero amount needs no special case.
      OP_ROR: begin
        rot                = {a_i, a_i} >> sh;
        res_o[DATA_W-1:0]  = rot[DATA_W-1:0];
      end
      OP_ROL: begin
        rot                = {a_i, a_i} << sh;
        res_o[DATA_W-1:0]  = rot[2*DATA_W-1:DATA_W];
      end
      OP_AND: res_o[DATA_W-1:0] = a_i & b_i;
      OP_OR:  res_o[DATA_W-1:0] = a_i | b_i;
      OP_MUL: res_o = a_ext * b_ext;
      OP_DIV: begin
        if (b_i != '0) begin
          res_o[DATA_W-1:0]        = $signed(a_i) / $signed(b_i);
          res_o[2*DATA_W-1:DATA_W] = $signed(a_i) % $signed(b_i);
        end
      end
      OP_NEG: res_o[DATA_W-1:0] = -b_i;
      OP_NOT: res_o[DATA_W-1:0] = ~b_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/bus_datapath_reg32.sv
// reg32: DATA_W-bit register with load enable and synchronous clear.
//   clk_i   - rising-edge clock
//   clear_i - synchronous active-high clear (wins over en_i)
//   en_i    - load enable
//   d_i     - load data
//   q_o     - register contents
module reg32
  import bus_datapath_pkg::*;
(
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bus_datapath.sv
// bus_datapath: single-bus 32-bit CPU datapath.
//   clk, Clear           - clock, synchronous active-high clear of all registers
//   R0in..R7in           - load general registers from the bus
//   HIin..MDRin, Zin     - special register loads (Z loads the ALU result)
//   IncPC                - PC increment (PCin has priority)
//   Read, Mdatain        - MDR source select and memory read data
//   R0out..R15out, HIout, LOout, Zhiout, Zlowout, PCout, MDRout, InPortout,
//   Cout                 - bus source selects, listed in priority order
//   IRout                - ALU opcode
//   Busout, R0_out       - observed bus value and R0 contents
module bus_datapath
  import bus_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              Clear,
  input  logic              Read,
  input  logic              R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic              HIin, LOin, PCin, IRin, Yin, MARin, MDRin,
  input  logic              Zin,
  input  logic              IncPC,
  input  logic              R0out, R1out, R2out, R3out,
  input  logic              R4out, R5out, R6out, R7out,
  input  logic              R8out, R9out, R10out, R11out,
  input  logic              R12out, R13out, R14out, R15out,
  input  logic              HIout, LOout, Zhiout, Zlowout,
  input  logic              PCout, MDRout, InPortout, Cout,
  input  logic [DATA_W-1:0] Mdatain,
  input  logic [4:0]        IRout,
  output logic [DATA_W-1:0] Busout,
  output logic [DATA_W-1:0] R0_out
);

  logic [15:0]         rin_w;
  logic [15:0]         rout_w;
  logic [DATA_W-1:0]   gpr_q [16];
  logic [DATA_W-1:0]   bus_w;
  logic [DATA_W-1:0]   hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q, zhi_q, zlo_q;
  logic [DATA_W-1:0]   pc_d, mdr_d, c_w;
  logic [2*DATA_W-1:0] alu_res;
  logic                unused_ok;

  // R8..R15 have no load strobe; their enables are tied low.
  assign rin_w  = {8'b0, R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign rout_w = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  for (genvar g = 0; g < 16; g++) begin : g_gpr
    reg32 u_gpr (
      .clk_i  (clk),
      .clear_i(Clear),
      .en_i   (rin_w[g]),
      .d_i    (bus_w),
      .q_o    (gpr_q[g])
    );
  end

  assign pc_d  = PCin ? bus_w : pc_q + 32'd1;
  assign mdr_d = Read ? Mdatain : bus_w;
  assign c_w   = {{(DATA_W-19){ir_q[18]}}, ir_q[18:0]};

  reg32 u_hi  (.clk_i(clk), .clear_i(Clear), .en_i(HIin),          .d_i(bus_w),                     .q_o(hi_q));
  reg32 u_lo  (.clk_i(clk), .clear_i(Clear), .en_i(LOin),          .d_i(bus_w),                     .q_o(lo_q));
  reg32 u_pc  (.clk_i(clk), .clear_i(Clear), .en_i(PCin | IncPC),  .d_i(pc_d),                      .q_o(pc_q));
  reg32 u_ir  (.clk_i(clk), .clear_i(Clear), .en_i(IRin),          .d_i(bus_w),                     .q_o(ir_q));
  reg32 u_y   (.clk_i(clk), .clear_i(Clear), .en_i(Yin),           .d_i(bus_w),                     .q_o(y_q));
  reg32 u_mar (.clk_i(clk), .clear_i(Clear), .en_i(MARin),         .d_i(bus_w),                     .q_o(mar_q));
  reg32 u_mdr (.clk_i(clk), .clear_i(Clear), .en_i(MDRin),         .d_i(mdr_d),                     .q_o(mdr_q));
  reg32 u_zhi (.clk_i(clk), .clear_i(Clear), .en_i(Zin),           .d_i(alu_res[2*DATA_W-1:DATA_W]), .q_o(zhi_q));
  reg32 u_zlo (.clk_i(clk), .clear_i(Clear), .en_i(Zin),           .d_i(alu_res[DATA_W-1:0]),       .q_o(zlo_q));

  alu u_alu (
    .op_i (IRout),
    .a_i  (y_q),
    .b_i  (bus_w),
    .res_o(alu_res)
  );

  // Sources are applied lowest priority first so the highest asserted one wins.
  always_comb begin
    bus_w = '0;
    if (Cout)      bus_w = c_w;
    if (InPortout) bus_w = '0;
    if (MDRout)    bus_w = mdr_q;
    if (PCout)     bus_w = pc_q;
    if (Zlowout)   bus_w = zlo_q;
    if (Zhiout)    bus_w = zhi_q;
    if (LOout)     bus_w = lo_q;
    if (HIout)     bus_w = hi_q;
    for (int unsigned i = 16; i > 0; i--) begin
      if (rout_w[i-1]) bus_w = gpr_q[i-1];
    end
  end

  // MAR and the upper IR bits have no consumer inside this slice.
  assign unused_ok = ^{mar_q, ir_q[DATA_W-1:19]};

  assign Busout = bus_w;
  assign R0_out = gpr_q[0];

endmodule

// File: tb/tb_bus_datapath.sv
module tb_bus_datapath;
  import bus_datapath_pkg::*;

  logic        clk = 1'b0;
  logic        Clear, Read;
  logic [7:0]  rin;
  logic [15:0] rout;
  logic        HIin, LOin, PCin, IRin, Yin, MARin, MDRin, Zin, IncPC;
  logic        HIout, LOout, Zhiout, Zlowout, PCout, MDRout, InPortout, Cout;
  logic [31:0] Mdatain;
  logic [4:0]  IRout;
  logic [31:0] Busout, R0_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sbq[$];

  bus_datapath dut (
    .clk(clk), .Clear(Clear), .Read(Read),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin), .Zin(Zin), .IncPC(IncPC),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Zhiout(Zhiout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
    .Mdatain(Mdatain), .IRout(IRout), .Busout(Busout), .R0_out(R0_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Clear = 0; Read = 0; rin = '0; rout = '0;
    HIin = 0; LOin = 0; PCin = 0; IRin = 0; Yin = 0; MARin = 0; MDRin = 0;
    Zin = 0; IncPC = 0;
    HIout = 0; LOout = 0; Zhiout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
    InPortout = 0; Cout = 0;
    Mdatain = '0; IRout = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  // Let the combinational bus settle, then compare it with the oldest expectation.
  task automatic observe();
    exp_t e;
    #2;
    if (sbq.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check(e.tag, Busout, e.val);
    end
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Read = 1; Mdatain = v; MDRin = 1;
    tick();
  endtask

  task automatic load_r(input int unsigned i, input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; rin[i] = 1;
    push($sformatf("ld_r%0d_bus", i), v);
    observe();
    tick();
  endtask

  task automatic read_r(input int unsigned i, input logic [31:0] v);
    rout[i] = 1;
    push($sformatf("rd_r%0d", i), v);
    observe();
    tick();
  endtask

  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r, ua, ub, q, rm;
    logic [63:0] p;
    int unsigned n;
    n  = b[4:0];
    ua = a[31] ? -a : a;
    ub = b[31] ? -b : b;
    r  = a;
    case (op)
      5'd3:  return {32'd0, a + b};
      5'd4:  return {32'd0, a - b};
      5'd5:  return {32'd0, a >> n};
      5'd6:  return {32'd0, a << n};
      5'd7: begin
        for (int unsigned k = 0; k < n; k++) r = {r[0], r[31:1]};
        return {32'd0, r};
      end
      5'd8: begin
        for (int unsigned k = 0; k < n; k++) r = {r[30:0], r[31]};
        return {32'd0, r};
      end
      5'd9:  return {32'd0, a & b};
      5'd10: return {32'd0, a | b};
      5'd14: begin
        p = {32'd0, ua} * {32'd0, ub};
        if (a[31] ^ b[31]) p = -p;
        return p;
      end
      5'd15: begin
        if (b == 32'd0) return 64'd0;
        q  = ua / ub;
        rm = ua % ub;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) rm = -rm;
        return {rm, q};
      end
      5'd16: return {32'd0, -b};
      5'd17: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] z;
    z = model(op, a, b);
    load_mdr(a);
    MDRout = 1; Yin = 1;
    tick();
    load_mdr(b);
    MDRout = 1; IRout = op; Zin = 1;
    tick();
    Zlowout = 1;
    push($sformatf("zlo_op%0d", op), z[31:0]);
    observe();
    tick();
    Zhiout = 1;
    push($sformatf("zhi_op%0d", op), z[63:32]);
    observe();
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  ops [14];
    logic [31:0] ra, rb;
    logic [4:0]  rop;
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
            5'd14, 5'd15, 5'd16, 5'd17, 5'd0, 5'd31};
    idle();
    Clear = 1;
    tick();
    Clear = 1;
    tick();
    check("rst_r0", R0_out, 32'd0);
    push("rst_bus_idle", 32'd0);
    observe();
    tick();

    // Load R1 = 25: MDR captures Mdatain while the bus still shows the old MDR.
    Read = 1; Mdatain = 32'd25; MDRin = 1; MDRout = 1;
    push("mdr_old", 32'd0);
    observe();
    tick();
    MDRout = 1; rin[1] = 1;
    push("mdr_25", 32'd25);
    observe();
    tick();
    check("r0_unchanged", R0_out, 32'd0);
    read_r(1, 32'd25);

    // OR: Y = 30, bus = R1 (25) -> 31.
    load_mdr(32'd30);
    MDRout = 1; Yin = 1;
    tick();
    rout[1] = 1; IRout = OP_OR; Zin = 1;
    push("or_operand", 32'd25);
    observe();
    tick();
    Zlowout = 1;
    push("or_result", 32'd31);
    observe();
    tick();

    alu_run(OP_ADD, 32'd7, 32'd5);
    alu_run(OP_SUB, 32'd7, 32'd5);
    alu_run(OP_MUL, 32'hFFFF_FFFD, 32'd4);
    alu_run(OP_DIV, 32'd17, 32'd5);
    alu_run(OP_DIV, 32'd7, 32'd0);
    alu_run(OP_DIV, -32'd17, 32'd5);
    alu_run(OP_SHR, 32'h8000_00F0, 32'd4);
    alu_run(OP_SHL, 32'h8000_00F1, 32'd31);
    alu_run(OP_ROR, 32'h0000_00F1, 32'd4);
    alu_run(OP_ROL, 32'hF000_0001, 32'd0);
    alu_run(OP_NEG, 32'd1, 32'd5);
    alu_run(OP_NOT, 32'd1, 32'h0F0F_0000);
    alu_run(5'd0, 32'd9, 32'd9);
    for (int i = 0; i < 16; i++) begin
      rop = ops[$urandom_range(0, 13)];
      ra  = $urandom;
      rb  = $urandom;
      if (rop == 5'd15) begin
        rb = $urandom_range(2, 1000);
        if ($urandom_range(0, 1) == 1) rb = -rb;
      end
      alu_run(rop, ra, rb);
    end

    // Bus priority and idle.
    push("bus_idle", 32'd0);
    observe();
    tick();
    load_r(0, 32'h55);
    load_mdr(32'hFFFF_FFFF);
    MDRout = 1; PCin = 1;
    tick();
    rout[0] = 1; PCout = 1;
    push("prio_r0_pc", 32'h55);
    observe();
    tick();
    IncPC = 1;
    tick();
    PCout = 1;
    push("pc_wrap", 32'd0);
    observe();
    tick();
    load_mdr(32'd8);
    MDRout = 1; PCin = 1; IncPC = 1;
    tick();
    PCout = 1;
    push("pcin_wins", 32'd8);
    observe();
    tick();

    load_mdr(32'h111);
    MDRout = 1; HIin = 1;
    tick();
    load_mdr(32'h222);
    MDRout = 1; LOin = 1;
    tick();
    HIout = 1; LOout = 1;
    push("prio_hi_lo", 32'h111);
    observe();
    tick();
    LOout = 1; Zlowout = 1;
    push("prio_lo_zlo", 32'h222);
    observe();
    tick();
    rout[1] = 1; HIout = 1;
    push("prio_r1_hi", 32'd25);
    observe();
    tick();
    rout[8] = 1; HIout = 1;
    push("prio_r8_hi", 32'd0);
    observe();
    tick();

    // C is sign-extended IR[18:0]; InPort outranks C and reads 0.
    load_mdr(32'h0004_0001);
    MDRout = 1; IRin = 1;
    tick();
    Cout = 1;
    push("c_neg", 32'hFFFC_0001);
    observe();
    tick();
    InPortout = 1; Cout = 1;
    push("inport_c", 32'd0);
    observe();
    tick();
    load_mdr(32'hFFF3_FFFF);
    MDRout = 1; IRin = 1;
    tick();
    Cout = 1;
    push("c_pos", 32'h0003_FFFF);
    observe();
    tick();

    // Self reload, fan-out capture, MDR from bus.
    rout[1] = 1; rin[1] = 1;
    tick();
    read_r(1, 32'd25);
    load_mdr(32'h77);
    MDRout = 1; rin[2] = 1; rin[3] = 1; HIin = 1;
    tick();
    read_r(2, 32'h77);
    read_r(3, 32'h77);
    HIout = 1;
    push("fanout_hi", 32'h77);
    observe();
    tick();
    rout[1] = 1; MDRin = 1; Read = 0;
    tick();
    MDRout = 1;
    push("mdr_from_bus", 32'd25);
    observe();
    tick();

    // Clear with enables active.
    load_mdr(32'd9);
    MDRout = 1; Yin = 1;
    tick();
    Clear = 1; Read = 1; Mdatain = 32'd99; MDRin = 1; MDRout = 1;
    rin = 8'hFF; Yin = 1; Zin = 1; IRout = OP_ADD; PCin = 1; IncPC = 1;
    HIin = 1; LOin = 1; IRin = 1;
    tick();
    check("clr_r0", R0_out, 32'd0);
    PCout = 1;   push("clr_pc", 32'd0);   observe(); tick();
    HIout = 1;   push("clr_hi", 32'd0);   observe(); tick();
    LOout = 1;   push("clr_lo", 32'd0);   observe(); tick();
    Zlowout = 1; push("clr_zlo", 32'd0);  observe(); tick();
    Zhiout = 1;  push("clr_zhi", 32'd0);  observe(); tick();
    MDRout = 1;  push("clr_mdr", 32'd0);  observe(); tick();
    Cout = 1;    push("clr_ir", 32'd0);   observe(); tick();
    read_r(1, 32'd0);
    read_r(7, 32'd0);
    IRout = OP_ADD; Zin = 1;
    tick();
    Zlowout = 1; push("clr_y", 32'd0);    observe(); tick();

    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
